// File: rtl/dma_pkg.sv
// Shared definitions for the DMA descriptor processor: command FSM encoding
// and descriptor geometry used by fetch and status-update address math.
package dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RD_CMD = 2'd1,
        ST_WR_CMD = 2'd2
    } dma_state_t;

    localparam int DESC_WORDS = 7;
    localparam int DESC_BYTES = 28;

    // Encoding of the round-robin history bit
    localparam logic GNT_WR = 1'b0;
    localparam logic GNT_RD = 1'b1;

endpackage

// File: rtl/dma_rr_arb2.sv
// Two-requester round-robin arbiter (read fetch vs. status write) with a
// single history bit; grants are combinational, history updates on take.
module dma_rr_arb2
    import dma_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic req_rd,
    input  logic req_wr,
    input  logic take,
    output logic gnt_rd,
    output logic gnt_wr
);

    logic last_grant;

    always_comb begin
        gnt_rd = 1'b0;
        gnt_wr = 1'b0;
        if (req_rd && req_wr) begin
            if (last_grant == GNT_RD) gnt_wr = 1'b1;
            else                      gnt_rd = 1'b1;
        end else begin
            gnt_rd = req_rd;
            gnt_wr = req_wr;
        end
    end

    // Reset pretends a read went last so the status FIFO drains first
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= GNT_RD;
        end else if (take && (gnt_rd || gnt_wr)) begin
            last_grant <= gnt_rd ? GNT_RD : GNT_WR;
        end
    end

endmodule

// File: rtl/dma_avmm_arbiter.sv
// Shares one Avalon-MM master between descriptor burst fetches and status
// write-backs; tracks outstanding read bursts and steers returned beats.
module dma_avmm_arbiter
    import dma_pkg::*;
#(
    parameter int MAX_BURSTS = 2,
    parameter int DESC_WORDS = dma_pkg::DESC_WORDS
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rd_req_i,
    input  logic [31:0] rd_addr_i,
    output logic        rd_wait_o,
    output logic [31:0] rd_data_o,
    output logic        rd_data_valid_o,
    output logic        rd_last_o,
    input  logic        wr_req_i,
    input  logic [31:0] wr_addr_i,
    input  logic [31:0] wr_data_i,
    input  logic [3:0]  wr_be_i,
    output logic        wr_wait_o,
    output logic [31:0] avm_address_o,
    output logic        avm_read_o,
    output logic        avm_write_o,
    output logic [31:0] avm_writedata_o,
    output logic [3:0]  avm_byteenable_o,
    output logic [3:0]  avm_burstcount_o,
    input  logic        avm_waitrequest_i,
    input  logic [31:0] avm_readdata_i,
    input  logic        avm_readdatavalid_i,
    output logic        busy_o,
    output logic        err_o
);

    dma_state_t  state;
    logic [2:0]  burst_cnt;
    logic [3:0]  beat_cnt;
    logic        gnt_rd, gnt_wr;
    logic        rd_elig, rd_accept, wr_accept;
    logic        beat_ok, beat_spur, beat_last;

    assign rd_elig   = rd_req_i && (burst_cnt < 3'(MAX_BURSTS));
    assign rd_accept = (state == ST_RD_CMD) && !avm_waitrequest_i;
    assign wr_accept = (state == ST_WR_CMD) && !avm_waitrequest_i;

    // Beats with nothing outstanding are dropped and flagged
    assign beat_ok   = avm_readdatavalid_i && (burst_cnt != 3'd0);
    assign beat_spur = avm_readdatavalid_i && (burst_cnt == 3'd0);
    assign beat_last = beat_ok && (beat_cnt == 4'(DESC_WORDS - 1));

    assign rd_wait_o = !rd_accept;
    assign wr_wait_o = !wr_accept;
    assign busy_o    = (state != ST_IDLE) || (burst_cnt != 3'd0);

    dma_rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req_rd  (rd_elig),
        .req_wr  (wr_req_i),
        .take    (state == ST_IDLE),
        .gnt_rd  (gnt_rd),
        .gnt_wr  (gnt_wr)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= ST_IDLE;
            avm_address_o    <= 32'h0;
            avm_read_o       <= 1'b0;
            avm_write_o      <= 1'b0;
            avm_writedata_o  <= 32'h0;
            avm_byteenable_o <= 4'h0;
            avm_burstcount_o <= 4'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt_wr) begin
                        state            <= ST_WR_CMD;
                        avm_write_o      <= 1'b1;
                        avm_address_o    <= wr_addr_i;
                        avm_writedata_o  <= wr_data_i;
                        avm_byteenable_o <= wr_be_i;
                        avm_burstcount_o <= 4'd1;
                    end else if (gnt_rd) begin
                        state            <= ST_RD_CMD;
                        avm_read_o       <= 1'b1;
                        avm_address_o    <= rd_addr_i;
                        avm_byteenable_o <= 4'hF;
                        avm_burstcount_o <= 4'(DESC_WORDS);
                    end
                end
                ST_RD_CMD, ST_WR_CMD: begin
                    if (!avm_waitrequest_i) begin
                        state       <= ST_IDLE;
                        avm_read_o  <= 1'b0;
                        avm_write_o <= 1'b0;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    avm_read_o  <= 1'b0;
                    avm_write_o <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            burst_cnt       <= 3'd0;
            beat_cnt        <= 4'd0;
            err_o           <= 1'b0;
            rd_data_o       <= 32'h0;
            rd_data_valid_o <= 1'b0;
            rd_last_o       <= 1'b0;
        end else begin
            case ({rd_accept, beat_last})
                2'b10:   burst_cnt <= burst_cnt + 3'd1;
                2'b01:   burst_cnt <= burst_cnt - 3'd1;
                default: burst_cnt <= burst_cnt;
            endcase
            if (beat_ok) begin
                beat_cnt  <= beat_last ? 4'd0 : beat_cnt + 4'd1;
                rd_data_o <= avm_readdata_i;
            end
            if (beat_spur) err_o <= 1'b1;
            rd_data_valid_o <= beat_ok;
            rd_last_o       <= beat_last;
        end
    end

endmodule

// File: doc/dma_avmm_arbiter.md
# dma_avmm_arbiter

Shares the DMA descriptor processor's single Avalon-MM master port between two requesters:

- **Descriptor fetch:** 7-word (28-byte, 0x1C stride) burst reads.
- **Descriptor status write-back:** single-word partial writes with byteenable, issued by the status-update block.

Arbitration is round-robin with registered master-side commands. The block tracks outstanding read bursts and steers returned read data back to the fetch requester with a last-beat marker. It sits between the descriptor fetch and status-update blocks and the interconnect.

## Interface
Parameters:
- `MAX_BURSTS`, default 2: maximum read bursts in flight (range 1–7).
- `DESC_WORDS`, default 7: beats per descriptor read burst.

Ports:
- `clk`, in, 1: single clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `rd_req_i`, in, 1: fetch requests a burst read; held until accepted.
- `rd_addr_i`, in, 32: byte address of the descriptor.
- `rd_wait_o`, out, 1: low for exactly the accept cycle of a read command, high otherwise.
- `rd_data_o`, out, 32: returned read beat.
- `rd_data_valid_o`, out, 1: `rd_data_o` valid.
- `rd_last_o`, out, 1: marks the final beat of a burst.
- `wr_req_i`, in, 1: status-update write request; held until accepted.
- `wr_addr_i`, in, 32: byte address to write.
- `wr_data_i`, in, 32: write data.
- `wr_be_i`, in, 4: write byteenable.
- `wr_wait_o`, out, 1: low for exactly the accept cycle of a write command, high otherwise.
- `avm_address_o`, out, 32: registered command address.
- `avm_read_o`, out, 1: registered read strobe.
- `avm_write_o`, out, 1: registered write strobe.
- `avm_writedata_o`, out, 32: registered write data.
- `avm_byteenable_o`, out, 4: registered byteenable.
- `avm_burstcount_o`, out, 4: registered burst count.
- `avm_waitrequest_i`, in, 1: fabric stall.
- `avm_readdata_i`, in, 32: returned read data.
- `avm_readdatavalid_i`, in, 1: read data valid.
- `busy_o`, out, 1: FSM not in IDLE, or any read burst outstanding.
- `err_o`, out, 1: sticky; a read beat arrived with no burst outstanding.

## Operation
FSM states: IDLE, RD_CMD, WR_CMD.

- **IDLE:** grants one requester and loads the `avm_*` command registers.
  - Read grant → RD_CMD: `avm_read_o`=1, `avm_burstcount_o`=`DESC_WORDS`, `avm_byteenable_o`=4'hF.
  - Write grant → WR_CMD: `avm_write_o`=1, `avm_burstcount_o`=1, data and byteenable from the `wr_*` inputs.
- **RD_CMD / WR_CMD:** hold all `avm_*` outputs stable while `avm_waitrequest_i`=1.
  - On `avm_waitrequest_i`=0, the matching `*_wait_o` goes low that cycle.
  - Strobes clear on the next edge and the FSM returns to IDLE.
- **Read eligibility:** `rd_req_i`=1 and `burst_cnt` < `MAX_BURSTS`. Writes are always eligible, including while reads are outstanding.
- **Round-robin:** a 1-bit `last_grant` register.
  - When both requesters are eligible, the one not granted last wins.
  - Reset value favours write, so the status FIFO drains first.
- **`burst_cnt`** (3 bits):
  - +1 on read accept.
  - −1 on a valid beat with `beat_cnt`=`DESC_WORDS`−1.
  - Unchanged when both happen in the same cycle.
- **`beat_cnt`:** +1 per valid beat; wraps to 0 after the last beat.
- **Read return:** `rd_data_o`/`rd_data_valid_o` are `avm_readdata_i`/`avm_readdatavalid_i` registered by one cycle. `rd_last_o` is aligned with them.
- **Spurious beat:** a valid beat while `burst_cnt`=0 is dropped (no `rd_data_valid_o`) and sets `err_o`. Only reset clears `err_o`.
- **Requester rule:** requests are not withdrawn while `*_wait_o`=1. Address and data are captured at grant, so changes after grant are ignored.

## Timing
- **Reset (asynchronous assert, synchronous deassert):**
  - FSM = IDLE; `last_grant` favours write; all counters 0.
  - `avm_read_o`, `avm_write_o`, `rd_data_valid_o`, `rd_last_o`, `err_o`, `busy_o` = 0.
  - `avm_address_o`, `avm_writedata_o`, `rd_data_o` = 0; `avm_byteenable_o` = 0; `avm_burstcount_o` = 0.
  - `rd_wait_o` = `wr_wait_o` = 1.
- **Reset mid-operation:** the command is abandoned and outstanding bursts are forgotten. Beats arriving afterwards set `err_o`.
- **Command latency:** a request seen in IDLE at edge N drives the `avm` strobe after edge N. With waitrequest low, it is accepted in that same cycle (`*_wait_o` low). Minimum spacing between commands is 2 cycles.
- **Wait-path exception:** `rd_wait_o`/`wr_wait_o` are combinational from `avm_waitrequest_i` and the state; this is the only such path. All `avm_*` outputs are registered.
- **Read-data latency:** 1 cycle from fabric to `rd_*`.

## Structure
- **Shared package (`dma_pkg`):**
  - FSM state encoding: 2 bits.
  - `DESC_WORDS`=7.
  - `DESC_BYTES`=28 (0x1C), shared with the status-update address computation.
- **Sub-module:** one, `dma_rr_arb2`, a 2-requester round-robin arbiter holding `last_grant`.

## Test plan
- **Single write, no stall:** `wr_req_i`=1, addr 0x1000_001C, be 4'b1100, data 0x0000_00AA → `avm_write_o`=1 for exactly 1 cycle with those values; `wr_wait_o` low for 1 cycle.
- **Read burst:** rd addr 0x2000_0000; fabric stalls 3 cycles, then returns 7 beats 0..6 → `avm_read_o` held 4 cycles with burstcount 7; seven `rd_data_valid_o` pulses; `rd_last_o` only with beat 6; `burst_cnt` returns to 0.
- **Contention:** both requests held continuously for 4 grants → order W, R, W, R.
- **Burst limit:** 3 reads requested, no data returned → exactly 2 accepted; the third is accepted 1–2 cycles after the last beat of burst 0.
- **Same-cycle accept and last beat:** read accept coincides with a last beat → `burst_cnt` unchanged.
- **Error and reset:** a beat arrives with no burst outstanding → `err_o`=1 sticky, no `rd_data_valid_o`. Asserting `reset_n`=0 mid-burst → all outputs at reset values asynchronously.
